// File: rtl/imsic_msi_recv.sv
// imsic_msi_recv
//   Bus-side MSI receiver feeding the IMSIC per-hart CSR gate. 32-bit writes
//   to the seteipnum_le (offset 0x000) or seteipnum_be (offset 0x004) register
//   of an interrupt-file page are decoded into {hart, file, eid}. Valid MSIs are
//   queued in a small FIFO and presented one at a time using a level protocol:
//   o_msi_info_vld is high for HOLD_CYCLES clocks and then low for GAP_CYCLES
//   clocks. o_msi_info changes only on the edge where vld rises.
//
//   Ports:
//     clk, rstn       clock, asynchronous active-low reset
//     i_wr_vld        write request valid
//     o_wr_rdy        write request ready (low while the queue is full)
//     i_wr_addr       byte address within the IMSIC region
//     i_wr_data       write data
//     o_msi_info      {hart, file, eid}, MSB first
//     o_msi_info_vld  level-protocol valid toward the CSR gate
//     o_fifo_cnt      current queue occupancy
//     o_drop_cnt      saturating count of discarded writes
module imsic_msi_recv #(
   parameter  int NR_INTP_FILES   = 7,
   parameter  int NR_HARTS        = 4,
   parameter  int NR_HARTS_WIDTH  = 2,
   parameter  int NR_SRC          = 32,
   parameter  int ADDR_WIDTH      = 17,
   parameter  int FIFO_DEPTH      = 4,
   parameter  int HOLD_CYCLES     = 4,
   parameter  int GAP_CYCLES      = 4,
   localparam int NR_SRC_WIDTH    = $clog2(NR_SRC),
   localparam int INTP_FILE_WIDTH = $clog2(NR_INTP_FILES),
   localparam int MSI_INFO_WIDTH  = NR_HARTS_WIDTH + INTP_FILE_WIDTH + NR_SRC_WIDTH,
   localparam int CNT_W           = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      i_wr_vld,
   output logic                      o_wr_rdy,
   input  logic [ADDR_WIDTH-1:0]     i_wr_addr,
   input  logic [31:0]               i_wr_data,
   output logic [MSI_INFO_WIDTH-1:0] o_msi_info,
   output logic                      o_msi_info_vld,
   output logic [CNT_W-1:0]          o_fifo_cnt,
   output logic [7:0]                o_drop_cnt
);

   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int HART_LSB = 12 + INTP_FILE_WIDTH;
   localparam int HART_HI  = HART_LSB + NR_HARTS_WIDTH;
   localparam int TMR_MAX  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int TMR_W    = $clog2(TMR_MAX + 1);

   // HIGH is the only state decoded onto vld, and IDLE<->LOW differ in one bit,
   // so the combinational vld cannot glitch high on any state transition.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      HIGH = 2'b01,
      LOW  = 2'b10
   } state_t;

   // ---------------- decode ----------------
   logic [INTP_FILE_WIDTH-1:0] w_file;
   logic [NR_HARTS_WIDTH-1:0]  w_hart;
   logic [31:0]                w_eid;
   logic                       w_off_ok;
   logic                       w_upper_nz;
   logic                       w_dec_ok;
   logic                       w_accept;
   logic                       w_push;
   logic                       w_drop;
   logic [MSI_INFO_WIDTH-1:0]  w_info;

   assign w_file     = i_wr_addr[12 +: INTP_FILE_WIDTH];
   assign w_hart     = i_wr_addr[HART_LSB +: NR_HARTS_WIDTH];
   assign w_upper_nz = (i_wr_addr >> HART_HI) != '0;

   always_comb begin
      w_eid    = '0;
      w_off_ok = 1'b0;
      case (i_wr_addr[11:0])
         12'h000: begin
            w_eid    = i_wr_data;
            w_off_ok = 1'b1;
         end
         12'h004: begin
            w_eid    = {i_wr_data[7:0], i_wr_data[15:8], i_wr_data[23:16], i_wr_data[31:24]};
            w_off_ok = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_dec_ok = w_off_ok && !w_upper_nz
                     && (32'(w_file) < 32'(NR_INTP_FILES))
                     && (32'(w_hart) < 32'(NR_HARTS))
                     && (w_eid != '0)
                     && (w_eid < 32'(NR_SRC));

   assign w_info   = {w_hart, w_file, w_eid[NR_SRC_WIDTH-1:0]};
   assign o_wr_rdy = (o_fifo_cnt != CNT_W'(FIFO_DEPTH));
   assign w_accept = i_wr_vld & o_wr_rdy;
   assign w_push   = w_accept & w_dec_ok;
   assign w_drop   = w_accept & ~w_dec_ok;

   // ---------------- FIFO ----------------
   logic [MSI_INFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]          r_wptr;
   logic [PTR_W-1:0]          r_rptr;
   logic                      w_pop;
   logic                      w_nonempty;

   assign w_nonempty = (o_fifo_cnt != '0);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= w_info;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         o_fifo_cnt <= '0;
         o_drop_cnt <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   o_fifo_cnt <= o_fifo_cnt + CNT_W'(1);
            2'b01:   o_fifo_cnt <= o_fifo_cnt - CNT_W'(1);
            default: ;
         endcase
         if (w_drop && (o_drop_cnt != 8'hFF)) o_drop_cnt <= o_drop_cnt + 8'd1;
      end
   end

   // ---------------- pulse FSM ----------------
   state_t           r_state;
   state_t           w_next;
   logic [TMR_W-1:0] r_tmr;
   logic             w_tmr_zero;

   assign w_tmr_zero = (r_tmr == '0);

   // State register; the down-counter reloads whenever a state is entered.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= IDLE;
         r_tmr   <= '0;
      end else begin
         r_state <= w_next;
         if (w_next == HIGH && r_state != HIGH)     r_tmr <= TMR_W'(HOLD_CYCLES - 1);
         else if (w_next == LOW && r_state != LOW)  r_tmr <= TMR_W'(GAP_CYCLES - 1);
         else if (!w_tmr_zero)                      r_tmr <= r_tmr - TMR_W'(1);
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_nonempty) w_next = HIGH;
         HIGH:    if (w_tmr_zero) w_next = LOW;
         LOW:     if (w_tmr_zero) w_next = w_nonempty ? HIGH : IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      o_msi_info_vld = (r_state == HIGH);
      w_pop          = w_nonempty && ((r_state == IDLE) || (r_state == LOW && w_tmr_zero));
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)      o_msi_info <= '0;
      else if (w_pop) o_msi_info <= r_mem[r_rptr];
   end

endmodule

// File: tb/tb_imsic_msi_recv.sv
module tb_imsic_msi_recv;

   localparam int HOLD  = 4;
   localparam int GAP   = 4;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        i_wr_vld = 1'b0;
   logic        o_wr_rdy;
   logic [16:0] i_wr_addr = '0;
   logic [31:0] i_wr_data = '0;
   logic [9:0]  o_msi_info;
   logic        o_msi_info_vld;
   logic [2:0]  o_fifo_cnt;
   logic [7:0]  o_drop_cnt;

   always #5 clk = ~clk;

   imsic_msi_recv #(
      .NR_INTP_FILES (7),
      .NR_HARTS      (4),
      .NR_HARTS_WIDTH(2),
      .NR_SRC        (32),
      .ADDR_WIDTH    (17),
      .FIFO_DEPTH    (DEPTH),
      .HOLD_CYCLES   (HOLD),
      .GAP_CYCLES    (GAP)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .i_wr_vld      (i_wr_vld),
      .o_wr_rdy      (o_wr_rdy),
      .i_wr_addr     (i_wr_addr),
      .i_wr_data     (i_wr_data),
      .o_msi_info    (o_msi_info),
      .o_msi_info_vld(o_msi_info_vld),
      .o_fifo_cnt    (o_fifo_cnt),
      .o_drop_cnt    (o_drop_cnt)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference decode from the address map using plain arithmetic.
   function automatic bit decode(input logic [16:0] a, input logic [31:0] d, output logic [9:0] info);
      longint unsigned off, page, file, hart, eid, dd;
      off  = a % 4096;
      page = a / 4096;
      file = page % 8;
      hart = page / 8;
      dd   = d;
      info = '0;
      if (off == 0)      eid = dd;
      else if (off == 4) eid = ((dd % 256) << 24) + (((dd / 256) % 256) << 16)
                               + (((dd / 65536) % 256) << 8) + (dd / 16777216);
      else               return 1'b0;
      if (file >= 7 || hart >= 4 || eid == 0 || eid >= 32) return 1'b0;
      info = 10'(hart * 256 + file * 32 + eid);
      return 1'b1;
   endfunction

   // Behavioural model: each queued MSI gets a scheduled rise edge; pulses are
   // spaced HOLD+GAP apart and a fresh MSI rises one edge after its push.
   typedef struct {
      longint     rise;
      logic [9:0] info;
   } ent_t;

   ent_t       sq[$];
   longint     k = 0;
   longint     acc_k = 0;
   longint     m_rise = -1000;
   longint     last_rise = -1000;
   int         m_cnt = 0;
   int         m_drop = 0;
   logic [9:0] m_info = '0;
   int         pre;
   bit         popped;
   logic [9:0] dinf;
   longint     nr;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_cnt = 0; m_drop = 0; m_info = '0;
         m_rise = -1000; last_rise = -1000;
         sq.delete();
      end else begin
         k++;
         pre = m_cnt;
         popped = 1'b0;
         if (sq.size() > 0 && sq[0].rise == k) begin
            m_info = sq[0].info;
            m_rise = k;
            void'(sq.pop_front());
            popped = 1'b1;
         end
         if (i_wr_vld && pre != DEPTH) begin
            acc_k = k;
            if (decode(i_wr_addr, i_wr_data, dinf)) begin
               nr = (k + 1 > last_rise + HOLD + GAP) ? k + 1 : last_rise + HOLD + GAP;
               sq.push_back('{nr, dinf});
               last_rise = nr;
               m_cnt++;
            end else if (m_drop < 255) begin
               m_drop++;
            end
         end
         if (popped) m_cnt--;
      end
   end

   // Compare process plus pulse recording for the directed checks.
   longint     obs_k[$];
   logic [9:0] obs_info[$];
   int         runs[$];
   int         run = 0;
   logic       pv = 1'b0;
   bit         seen_full = 1'b0;

   always @(negedge clk) begin
      chk("vld",  o_msi_info_vld, 64'((k - m_rise) < HOLD));
      chk("info", o_msi_info, m_info);
      chk("cnt",  o_fifo_cnt, m_cnt);
      chk("rdy",  o_wr_rdy, m_cnt != DEPTH);
      chk("drop", o_drop_cnt, m_drop);
      if (o_msi_info_vld && !pv) begin
         obs_k.push_back(k);
         obs_info.push_back(o_msi_info);
      end
      if (o_msi_info_vld) run = pv ? run + 1 : 1;
      else if (pv) runs.push_back(run);
      if (o_fifo_cnt == 3'd4 && !o_wr_rdy) seen_full = 1'b1;
      pv = o_msi_info_vld;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic clear_obs();
      obs_k.delete();
      obs_info.delete();
      runs.delete();
   endtask

   // Called at posedge+2; returns at posedge+2 after the accepting edge.
   task automatic wr(input logic [16:0] a, input logic [31:0] d);
      logic r;
      i_wr_vld  = 1'b1;
      i_wr_addr = a;
      i_wr_data = d;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         r = o_wr_rdy;
         @(posedge clk);
         #2;
         if (r) begin
            i_wr_vld = 1'b0;
            return;
         end
      end
      chk("wr_timeout", 0, 1);
      i_wr_vld = 1'b0;
   endtask

   task automatic single_check(input string tag, input logic [16:0] a, input logic [31:0] d);
      longint ak;
      clear_obs();
      wr(a, d);
      ak = acc_k;
      step(14);
      chk({tag, "_pulses"}, obs_k.size(), 1);
      if (obs_k.size() >= 1) begin
         chk({tag, "_info"}, obs_info[0], 10'h145);
         chk({tag, "_rise"}, obs_k[0] - ak, 1);
      end
      if (runs.size() >= 1) chk({tag, "_high"}, runs[0], HOLD);
      else chk({tag, "_high_seen"}, 0, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0]  pin;
      logic [1:0]  h;
      logic [2:0]  f;
      logic [11:0] off;
      logic [31:0] e;
      logic [31:0] d;
      int          wt;

      #1 rstn = 1'b0;
      #2;
      chk("rst_vld",  o_msi_info_vld, 0);
      chk("rst_info", o_msi_info, 0);
      chk("rst_cnt",  o_fifo_cnt, 0);
      chk("rst_drop", o_drop_cnt, 0);
      chk("rst_rdy",  o_wr_rdy, 1);
      step(2);
      rstn = 1'b1;
      step(2);

      // Pin the model decode with hand-computed values.
      chk("model_le", 64'(decode(17'h0A000, 32'd5, pin)), 1);
      chk("model_le_info", pin, 10'h145);
      chk("model_be", 64'(decode(17'h0A004, 32'h0500_0000, pin)), 1);
      chk("model_be_info", pin, 10'h145);
      chk("model_bad", 64'(decode(17'h07000, 32'd5, pin)), 0);

      single_check("le", 17'h0A000, 32'd5);
      chk("le_drop", o_drop_cnt, 0);
      single_check("be", 17'h0A004, 32'h0500_0000);

      // Drops.
      clear_obs();
      wr(17'h07000, 32'd5);
      wr(17'h00008, 32'd5);
      wr(17'h00000, 32'd0);
      wr(17'h00000, 32'd32);
      step(10);
      chk("drop4", o_drop_cnt, 4);
      chk("drop_pulses", obs_k.size(), 0);
      repeat (300) wr(17'h07000, 32'd1);
      step(2);
      chk("drop_sat", o_drop_cnt, 255);

      // Backpressure.
      clear_obs();
      seen_full = 1'b0;
      for (int unsigned i = 1; i <= 7; i++) wr(17'h00000, 32'(i));
      step(70);
      chk("bp_pulses", obs_k.size(), 7);
      for (int i = 0; i < obs_k.size(); i++) begin
         chk("bp_eid", obs_info[i], 10'(i + 1));
         if (i > 0) chk("bp_space", obs_k[i] - obs_k[i-1], HOLD + GAP);
      end
      chk("bp_full", seen_full, 1);
      chk("bp_cnt0", o_fifo_cnt, 0);

      // Push while a pulse is high.
      clear_obs();
      wr(17'h00000, 32'd3);
      wt = 0;
      while (!o_msi_info_vld && wt < 20) begin
         @(negedge clk);
         wt++;
      end
      chk("pp_wait", o_msi_info_vld, 1);
      step(1);
      wr(17'h00000, 32'd9);
      step(30);
      chk("pp_pulses", obs_k.size(), 2);
      if (obs_k.size() >= 2) begin
         chk("pp_space", obs_k[1] - obs_k[0], HOLD + GAP);
         chk("pp_eid0", obs_info[0], 10'd3);
         chk("pp_eid1", obs_info[1], 10'd9);
      end

      // Reset during HIGH with two entries queued.
      wr(17'h00000, 32'd1);
      wr(17'h00000, 32'd2);
      wr(17'h00000, 32'd3);
      chk("pre_rst_cnt", o_fifo_cnt, 2);
      chk("pre_rst_vld", o_msi_info_vld, 1);
      rstn = 1'b0;
      #1;
      chk("mid_rst_vld",  o_msi_info_vld, 0);
      chk("mid_rst_cnt",  o_fifo_cnt, 0);
      chk("mid_rst_info", o_msi_info, 0);
      step(2);
      rstn = 1'b1;
      step(1);
      clear_obs();
      step(20);
      chk("post_rst_pulses", obs_k.size(), 0);
      single_check("post_rst", 17'h0A000, 32'd5);

      // Randomized traffic.
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(1, 0) == 1) begin
            h = 2'($urandom_range(3, 0));
            f = 3'($urandom_range(7, 0));
            case ($urandom_range(7, 0))
               0, 1, 2, 3: off = 12'h000;
               4, 5, 6:    off = 12'h004;
               default:    off = 12'h008;
            endcase
            e = 32'($urandom_range(40, 0));
            d = (off == 12'h004) ? {e[7:0], e[15:8], e[23:16], e[31:24]} : e;
            if ($urandom_range(7, 0) == 0) d = $urandom;
            if ($urandom_range(7, 0) == 0) wr(17'($urandom), d);
            else wr({h, f, off}, d);
         end else begin
            step(1);
         end
      end
      step(120);
      chk("rand_drain", o_fifo_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
